ntt_perm_frame_scheduler: RTL and testbench

//  Frame-level sequencer for the stage_N_permutation chain of the N=1024, 32-lane NTT.

---
 rtl/ntt_sched_pkg.sv | 23 ++
 rtl/ntt_frame_tag_fifo.sv | 58 +++++
 rtl/ntt_perm_frame_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_ntt_perm_frame_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_sched_pkg.sv
// Shared types and constants for the NTT permutation-chain frame scheduler.
// Frame geometry: N points per frame, INPUT_PER_CYCLE lanes per beat, so
// FRAME_BEATS beats per frame, indexed with BEAT_W bits.
// frame_tag_t travels through the tag FIFO: the frame id and the timestamp
// of the frame's perm_in_start cycle (used by the latency watchdog).
package ntt_sched_pkg;
    localparam int N               = 1024;
    localparam int INPUT_PER_CYCLE = 32;
    localparam int FRAME_BEATS     = N / INPUT_PER_CYCLE;
    localparam int BEAT_W          = 5;
    localparam int FRAME_ID_W      = 8;
    localparam int TS_W            = 16;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);

    typedef struct packed {
        logic [FRAME_ID_W-1:0] id;
        logic [TS_W-1:0]       ts;
    } frame_tag_t;

    typedef enum logic {IN_IDLE, IN_FRAME}   in_state_e;
    typedef enum logic {OUT_IDLE, OUT_FRAME} out_state_e;
endpackage

// File: rtl/ntt_frame_tag_fifo.sv
// Small circular FIFO of frame tags, one entry per frame in flight.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   push, push_tag      write a tag (dropped when full unless popping too)
//   pop                 drop the head entry (ignored when empty)
//   head                oldest entry, valid while !empty
//   empty, full         occupancy flags
// Simultaneous push and pop are allowed, including when full.
module ntt_frame_tag_fifo
    import ntt_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  frame_tag_t push_tag,
    input  logic       pop,
    output frame_tag_t head,
    output logic       empty,
    output logic       full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    frame_tag_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/ntt_perm_frame_scheduler.sv
// Frame-level sequencer for the permutation chain of the 1024-point,
// 32-lane NTT. Admits 32-beat input frames under a credit limit, pulses
// perm_in_start one cycle after beat 0 is accepted, and frames the output
// stream from the last stage's perm_out_start. Sticky error flags report
// input gaps, latency timeouts, spurious and overlapping out_start pulses;
// they never alter the data flow.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   src_valid / src_ready     upstream beat handshake; cap_en = both
//   in_beat                   index of the next input beat to accept
//   perm_in_start             pulse to stage 0, aligned with registered beat 0
//   perm_out_start            first-output-beat pulse from the last stage
//   out_valid/out_beat/out_last/out_frame_id   output stream framing
//   inflight, busy            frames outstanding, activity indication
//   err_clr                   clears the sticky error flags (set wins)
//   err_gap/err_timeout/err_spurious/err_overlap   sticky error flags
module ntt_perm_frame_scheduler
    import ntt_sched_pkg::*;
#(
    parameter  int MAX_INFLIGHT = 2,
    parameter  int LAT_MAX      = 256,
    localparam int INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic                  cap_en,
    output logic [BEAT_W-1:0]     in_beat,
    output logic                  perm_in_start,
    input  logic                  perm_out_start,
    output logic                  out_valid,
    output logic [BEAT_W-1:0]     out_beat,
    output logic                  out_last,
    output logic [FRAME_ID_W-1:0] out_frame_id,
    output logic [INF_W-1:0]      inflight,
    output logic                  busy,
    input  logic                  err_clr,
    output logic                  err_gap,
    output logic                  err_timeout,
    output logic                  err_spurious,
    output logic                  err_overlap
);
    in_state_e             in_state, in_state_nxt;
    out_state_e            out_state, out_state_nxt;
    logic                  run;
    logic [BEAT_W-1:0]     in_cnt;
    logic [BEAT_W-1:0]     out_cnt;
    logic [FRAME_ID_W-1:0] next_id;
    logic [FRAME_ID_W-1:0] cur_id;
    logic [TS_W-1:0]       ts;
    logic [TS_W-1:0]       age;
    logic                  start;
    logic                  out_go;
    logic                  gap_set, spur_set, ovl_set, tmo_set;
    logic                  fifo_empty, fifo_full;
    frame_tag_t            head;
    frame_tag_t            push_tag;

    // The tag carries the timestamp of the perm_in_start cycle (one after the
    // handshake), so the watchdog age equals the cycles since perm_in_start.
    assign push_tag = '{id: next_id, ts: ts + 1'b1};
    assign start    = (in_state == IN_IDLE) & src_valid & src_ready;
    assign cap_en   = src_valid & src_ready;
    assign in_beat  = in_cnt;
    assign busy     = (inflight != '0) | (in_state == IN_FRAME);
    assign age      = ts - head.ts;
    assign tmo_set  = ~fifo_empty & (age > TS_W'(LAT_MAX));

    ntt_frame_tag_fifo #(.DEPTH(MAX_INFLIGHT)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (start),
        .push_tag (push_tag),
        .pop      (out_go),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Input FSM. `run` holds src_ready low while reset is asserted and for the
    // first cycle after release, so every output reads 0 during reset.
    always_comb begin
        in_state_nxt = in_state;
        src_ready    = 1'b0;
        gap_set      = 1'b0;
        case (in_state)
            IN_IDLE: begin
                src_ready = run & (inflight < INF_W'(MAX_INFLIGHT));
                if (src_valid & src_ready) in_state_nxt = IN_FRAME;
            end
            IN_FRAME: begin
                // Fixed-latency datapath: beats are counted whether valid or not.
                src_ready = 1'b1;
                gap_set   = ~src_valid;
                if (in_cnt == LAST_BEAT) in_state_nxt = IN_IDLE;
            end
            default: in_state_nxt = IN_IDLE;
        endcase
    end

    // Output FSM. A pop exposes beat 0 in the same cycle as perm_out_start.
    always_comb begin
        out_state_nxt = out_state;
        out_go        = 1'b0;
        out_valid     = 1'b0;
        out_beat      = '0;
        out_last      = 1'b0;
        out_frame_id  = '0;
        spur_set      = 1'b0;
        ovl_set       = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (perm_out_start) begin
                    if (fifo_empty) begin
                        spur_set = 1'b1;
                    end else begin
                        out_go        = 1'b1;
                        out_valid     = 1'b1;
                        out_frame_id  = head.id;
                        out_state_nxt = OUT_FRAME;
                    end
                end
            end
            OUT_FRAME: begin
                out_valid    = 1'b1;
                out_beat     = out_cnt;
                out_frame_id = cur_id;
                ovl_set      = perm_out_start;
                out_last     = (out_cnt == LAST_BEAT);
                if (out_last) out_state_nxt = OUT_IDLE;
            end
            default: out_state_nxt = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_state      <= IN_IDLE;
            out_state     <= OUT_IDLE;
            run           <= 1'b0;
            in_cnt        <= '0;
            out_cnt       <= '0;
            next_id       <= '0;
            cur_id        <= '0;
            ts            <= '0;
            inflight      <= '0;
            perm_in_start <= 1'b0;
            err_gap       <= 1'b0;
            err_timeout   <= 1'b0;
            err_spurious  <= 1'b0;
            err_overlap   <= 1'b0;
        end else begin
            in_state      <= in_state_nxt;
            out_state     <= out_state_nxt;
            run           <= 1'b1;
            ts            <= ts + 1'b1;
            perm_in_start <= start;

            if (start) begin
                in_cnt  <= BEAT_W'(1);
                next_id <= next_id + 1'b1;
            end else if (in_state == IN_FRAME) begin
                in_cnt  <= (in_cnt == LAST_BEAT) ? '0 : in_cnt + 1'b1;
            end

            if (out_go) begin
                out_cnt <= BEAT_W'(1);
                cur_id  <= head.id;
            end else if (out_state == OUT_FRAME) begin
                out_cnt <= (out_cnt == LAST_BEAT) ? '0 : out_cnt + 1'b1;
            end

            // Start and out_last together leave the credit count unchanged.
            case ({start, out_last})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            err_gap      <= gap_set  | (err_gap      & ~err_clr);
            err_timeout  <= tmo_set  | (err_timeout  & ~err_clr);
            err_spurious <= spur_set | (err_spurious & ~err_clr);
            err_overlap  <= ovl_set  | (err_overlap  & ~err_clr);
        end
    end
endmodule

// File: tb/tb_ntt_perm_frame_scheduler.sv
// Bench for ntt_perm_frame_scheduler: a queue-based frame model predicts
// every output on every cycle; directed scenarios add literal expectations.
module tb_ntt_perm_frame_scheduler;
    localparam int MAXI = 2;
    localparam int LATM = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       src_valid, src_ready, cap_en;
    logic [4:0] in_beat;
    logic       perm_in_start, perm_out_start;
    logic       out_valid, out_last;
    logic [4:0] out_beat;
    logic [7:0] out_frame_id;
    logic [1:0] inflight;
    logic       busy, err_clr;
    logic       err_gap, err_timeout, err_spurious, err_overlap;

    ntt_perm_frame_scheduler #(.MAX_INFLIGHT(MAXI), .LAT_MAX(LATM)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
        .cap_en(cap_en), .in_beat(in_beat), .perm_in_start(perm_in_start),
        .perm_out_start(perm_out_start), .out_valid(out_valid), .out_beat(out_beat),
        .out_last(out_last), .out_frame_id(out_frame_id), .inflight(inflight),
        .busy(busy), .err_clr(err_clr), .err_gap(err_gap), .err_timeout(err_timeout),
        .err_spurious(err_spurious), .err_overlap(err_overlap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 40;
    bit auto_os = 1'b0;
    bit sched [int];

    typedef struct { int id; int start; } mtag_t;
    mtag_t q [$];
    bit m_run, m_in_act, m_pis, m_out_act, e_gap, e_to, e_sp, e_ov;
    int m_in_beat, m_out_beat, m_out_id, m_inf, m_nid;

    // observations of the DUT for the directed literal checks
    int hs_cyc, pis_cyc, os_cyc, os_id, ov_cnt, acc_cnt, os_cnt, prev_id;
    bit wrap_seen = 1'b0;

    function automatic logic [29:0] dut_vec();
        return {src_ready, cap_en, in_beat, perm_in_start, out_valid, out_beat, out_last,
                out_frame_id, inflight, busy, err_gap, err_timeout, err_spurious, err_overlap};
    endfunction

    always @(negedge clk) begin
        logic [29:0] exp_v;
        bit sr, hs, os, last, gap_s, to_s, sp_s, ov_s;
        mtag_t t;
        if (!rst) begin
            m_run = 0; m_in_act = 0; m_pis = 0; m_out_act = 0;
            e_gap = 0; e_to = 0; e_sp = 0; e_ov = 0;
            m_in_beat = 0; m_out_beat = 0; m_out_id = 0; m_inf = 0; m_nid = 0;
            q.delete(); sched.delete(); prev_id = -1;
            exp_v = '0;
            n_cmp++;
            if (dut_vec() !== exp_v) begin
                n_bad++;
                $display("FAIL reset_vec cyc=%0d dut=%h expected=%h", cyc, dut_vec(), exp_v);
            end
        end else begin
            if (cap_en && in_beat == 0) hs_cyc = cyc;
            if (perm_in_start) pis_cyc = cyc;
            if (cap_en) acc_cnt++;
            if (out_valid) ov_cnt++;
            if (out_valid && out_beat == 0) begin
                os_cyc = cyc; os_id = int'(out_frame_id); os_cnt++;
                if (prev_id == 255 && out_frame_id == 0) wrap_seen = 1'b1;
                prev_id = int'(out_frame_id);
            end

            sr   = m_run && (m_in_act || m_inf < MAXI);
            hs   = !m_in_act && sr && src_valid;
            os   = !m_out_act && perm_out_start && q.size() > 0;
            last = m_out_act && m_out_beat == 31;
            exp_v = {sr, sr && src_valid, 5'(m_in_act ? m_in_beat : 0), m_pis,
                     m_out_act || os, 5'(m_out_act ? m_out_beat : 0), last,
                     8'(m_out_act ? m_out_id : (os ? q[0].id : 0)), 2'(m_inf),
                     (m_inf != 0) || m_in_act, e_gap, e_to, e_sp, e_ov};
            n_cmp++;
            if (dut_vec() !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_vec cyc=%0d dut=%h expected=%h", cyc, dut_vec(), exp_v);
            end

            gap_s = m_in_act && !src_valid;
            to_s  = q.size() > 0 && (cyc - q[0].start) > LATM;
            sp_s  = !m_out_act && perm_out_start && q.size() == 0;
            ov_s  = m_out_act && perm_out_start;
            if (m_in_act) begin
                if (m_in_beat == 31) begin m_in_act = 0; m_in_beat = 0; end
                else m_in_beat++;
            end
            if (os) begin
                t = q.pop_front();
                m_out_id = t.id; m_out_act = 1; m_out_beat = 1;
            end else if (m_out_act) begin
                if (m_out_beat == 31) begin m_out_act = 0; m_out_beat = 0; end
                else m_out_beat++;
            end
            if (hs) begin
                m_in_act = 1; m_in_beat = 1;
                t.id = m_nid; t.start = cyc + 1;
                q.push_back(t);
                m_nid = (m_nid + 1) % 256;
                if (auto_os) sched[cyc + 1 + lat] = 1'b1;
            end
            m_pis = hs;
            m_inf = m_inf + int'(hs) - int'(last);
            e_gap = gap_s || (e_gap && !err_clr);
            e_to  = to_s  || (e_to  && !err_clr);
            e_sp  = sp_s  || (e_sp  && !err_clr);
            e_ov  = ov_s  || (e_ov  && !err_clr);
            m_run = 1;
        end
        cyc++;
    end

    task automatic lit(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit v, input bit fos, input bit clr);
        @(posedge clk); #1;
        src_valid      = v;
        err_clr        = clr;
        perm_out_start = fos | (sched.exists(cyc) != 0);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t_hs, t_pis, base, k;
        bit found;
        rst = 1'b0; src_valid = 1'b0; perm_out_start = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) step(0, 0, 0);

        // reset mid-frame with two frames in flight
        auto_os = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1, 0, 0);
            if (in_beat == 17 && inflight == 2) found = 1'b1;
        end
        lit("t1_reach_beat17_inflight2", int'(found), 1);
        @(posedge clk); #1;
        rst = 1'b0; src_valid = 1'b0; perm_out_start = 1'b0; err_clr = 1'b0;
        #1 lit("t1_outputs_zero_in_reset", int'(dut_vec()), 0);
        repeat (3) step(0, 0, 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) step(0, 0, 0);

        // single frame, then a second start coinciding with the first out_last
        auto_os = 1'b1; lat = 40;
        base = ov_cnt;
        for (int i = 0; i < 32; i++) step(1, 0, 0);
        t_hs = hs_cyc; t_pis = pis_cyc;
        lit("t2_pis_after_beat0", t_pis - t_hs, 1);
        lit("t2_inflight_one", int'(inflight), 1);
        repeat (40) step(0, 0, 0);
        step(1, 0, 0);
        lit("t2_out_last_coincident", int'(out_last), 1);
        lit("t2_start_coincident", int'(cap_en), 1);
        step(1, 0, 0);
        lit("t2_inflight_steady", int'(inflight), 1);
        lit("t2_out_valid_cycles", ov_cnt - base, 32);
        lit("t2_out_start_latency", os_cyc - t_pis, 40);
        lit("t2_first_id_after_reset", os_id, 0);
        repeat (30) step(1, 0, 0);
        repeat (100) step(0, 0, 0);
        lit("t2_inflight_drained", int'(inflight), 0);
        lit("t2_not_busy", int'(busy), 0);

        // credit stall with out_start withheld
        auto_os = 1'b0;
        base = acc_cnt;
        repeat (100) step(1, 0, 0);
        lit("t3_beats_before_stall", acc_cnt - base, 64);
        lit("t3_ready_low", int'(src_ready), 0);
        step(1, 1, 0);
        repeat (31) step(1, 0, 0);
        lit("t3_out_last", int'(out_last), 1);
        lit("t3_ready_low_at_last", int'(src_ready), 0);
        step(1, 0, 0);
        lit("t3_ready_after_last", int'(src_ready), 1);
        repeat (31) step(1, 0, 0);
        step(0, 1, 0);
        repeat (33) step(0, 0, 0);
        step(0, 1, 0);
        repeat (40) step(0, 0, 0);
        lit("t3_inflight_drained", int'(inflight), 0);

        // protocol errors
        auto_os = 1'b1; lat = 40;
        for (int i = 0; i < 32; i++) step(i != 10, 0, 0);
        lit("t4_err_gap", int'(err_gap), 1);
        repeat (90) step(0, 0, 0);
        step(0, 1, 0);
        lit("t4_spurious_no_valid", int'(out_valid), 0);
        step(0, 0, 0);
        lit("t4_err_spurious", int'(err_spurious), 1);
        base = ov_cnt;
        for (int i = 0; i < 32; i++) step(1, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(0, 0, 0);
            if (out_valid && out_beat == 4) found = 1'b1;
        end
        lit("t4_reach_out_beat4", int'(found), 1);
        step(0, 1, 0);
        lit("t4_overlap_beat5", int'(out_beat), 5);
        repeat (40) step(0, 0, 0);
        lit("t4_err_overlap", int'(err_overlap), 1);
        lit("t4_stream_uninterrupted", ov_cnt - base, 32);
        step(0, 0, 1);
        step(0, 0, 0);
        lit("t4_errors_cleared", int'({err_gap, err_timeout, err_spurious, err_overlap}), 0);

        // watchdog boundary
        lat = 257;
        for (int i = 0; i < 32; i++) step(1, 0, 0);
        repeat (300) step(0, 0, 0);
        lit("t5_timeout_257", int'(err_timeout), 1);
        step(0, 0, 1);
        lat = 256;
        for (int i = 0; i < 32; i++) step(1, 0, 0);
        repeat (330) step(0, 0, 0);
        lit("t5_no_timeout_256", int'(err_timeout), 0);

        // 260 frames offered back-to-back, id wrap
        lat = 32;
        base = os_cnt;
        for (int f = 0; f < 260; f++) begin
            k = 0;
            do begin step(1, 0, 0); k++; end while (!(cap_en && in_beat == 0) && k < 200);
            repeat (31) step(1, 0, 0);
        end
        repeat (200) step(0, 0, 0);
        lit("t6_frames_emitted", os_cnt - base, 260);
        lit("t6_id_wrap_255_to_0", int'(wrap_seen), 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            lat = $urandom_range(1, 300);
            step($urandom_range(0, 99) < 85, $urandom_range(0, 63) == 0,
                 $urandom_range(0, 49) == 0);
        end
        repeat (400) step(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
